fifo: RTL and testbench
=======================

# fifo

Synchronous first-in/first-out buffer for 32-bit words, 8 entries deep, with full/empty status flags. Sits between a producer and a consumer in the same clock domain. Both sides are strobe-driven: `write` pushes `data_in` and `read` pops into a registered `data_out`. A synchronous `clear` flushes the contents without a full reset.

## Interface
- `WIDTH`, default 32: data word width in bits.
- `DEPTH`, default 8: number of storage entries. Must be a power of two.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `clear`  in  1: synchronous, active-high flush.
- `write`  in  1: push request.
- `read`  in  1: pop request.
- `data_in`  in  WIDTH: word to push.
- `full`  out  1: high when `DEPTH` words are stored.
- `empty`  out  1: high when no words are stored.
- `data_out`  out  WIDTH: registered word from the most recent successful pop.

## Operation
- State:
  - storage array of `DEPTH` × `WIDTH`;
  - write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo `DEPTH`;
  - occupancy count, log2(DEPTH)+1 bits, range 0..DEPTH.
- Flags are derived combinationally from registered count:
  - `full` = (count == DEPTH);
  - `empty` = (count == 0).
- Priority at each rising edge: `reset` > `clear` > read/write.
- `reset`: pointers = 0, count = 0, `data_out` = 0. Storage contents are don't-care.
- `clear`: pointers = 0, count = 0. `data_out` holds its value. Any read/write in the same cycle is discarded.
- Write performed iff `write` && !`full`:
  - mem[wptr] <= `data_in`;
  - wptr advances by 1, wrapping at DEPTH-1 → 0.
- Read performed iff `read` && !`empty`:
  - `data_out` <= mem[rptr];
  - rptr advances by 1, wrapping at DEPTH-1 → 0.
- Count update: +1 on write only, -1 on read only, unchanged when both are performed or neither is.
- Write when full: silently dropped. Storage, pointers and count are unchanged, even if `read` is also asserted.
- Read when empty: ignored. `data_out` holds its previous value, even if `write` is also asserted.
- Simultaneous read and write when neither full nor empty: both are performed. The read returns the oldest entry; the new word is queued behind it.
- No overflow or underflow error outputs.
- Inputs are sampled only at the rising edge. X/undriven control inputs are a bench error and not a required-behaviour case.

## Timing
- Every output is registered state (or a pure function of registered count). Flags change only after a rising edge.
- Write latency: a word pushed at edge N can be popped at edge N+1 at the earliest. `empty` falls after edge N.
- Read latency: `data_out` shows the popped word immediately after the edge at which `read` was sampled, i.e. 1 cycle.
- `full` rises after the edge that stores the DEPTH-th word. It falls after the first subsequent pop.
- `empty` rises after the edge that pops the last word, or after a `clear`/`reset` edge.
- Reset or clear asserted mid-operation takes effect at that edge. Data in flight is lost. From the next cycle `empty`=1 and `full`=0.
- Throughput: one push and/or one pop per cycle, sustained.

## Test plan
- Reset: hold `reset`=1 for one edge with `write`=`read`=0 → `empty`=1, `full`=0, `data_out`=0.
- Ordering: write 100, 150, 200 on three consecutive edges, then hold `read`=1 for four edges:
  - `data_out` = 100, 150, 200 on successive cycles;
  - `data_out` holds 200 on the fourth read (empty);
  - `empty`=1 after the third pop.
- Fill/full: after reset, write 100, 150, 200, 40, 70, 65, 15, 230:
  - `full`=1 after the eighth edge;
  - a further write of 99 is dropped;
  - eight reads return the eight values in order, then `empty`=1.
- Wrap-around: write 5 words, read 5, write 8 (values 1..8), read 8:
  - pointers wrap;
  - outputs are 1..8 in order;
  - `full` and `empty` are correct at each boundary.
- Clear: with 3 words stored, assert `clear` together with `write`=1 for one edge:
  - `empty`=1;
  - the write is discarded;
  - `data_out` is unchanged;
  - subsequent writes/reads start from a clean queue.
- Simultaneous: with 4 words stored, assert `read`=`write`=1 for 3 edges → count stays 4 and `data_out` returns the 3 oldest words. When full, `read`=`write`=1 pops one word and drops the write; count becomes 7. When empty, `read`=`write`=1 stores the word; `data_out` is unchanged.

Source files
------------

// File: rtl/fifo_if.sv
// fifo_if: groups the producer/consumer strobes, data and status of the FIFO.
//   clear    : synchronous flush request (producer/consumer -> FIFO)
//   write    : push strobe, qualifies data_in
//   read     : pop strobe
//   data_in  : word to push
//   full     : FIFO holds DEPTH words
//   empty    : FIFO holds no words
//   data_out : word from the most recent successful pop
// Modports: master = the side driving strobes, slave = the FIFO itself.
interface fifo_if #(
    parameter int WIDTH = 32
);
    logic             clear;
    logic             write;
    logic             read;
    logic [WIDTH-1:0] data_in;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] data_out;

    modport master (
        output clear, write, read, data_in,
        input  full, empty, data_out
    );

    modport slave (
        input  clear, write, read, data_in,
        output full, empty, data_out
    );
endinterface

// File: rtl/fifo.sv
// fifo: synchronous single-clock FIFO, WIDTH-bit words, DEPTH entries
// (DEPTH must be a power of two so the pointers wrap by plain overflow).
//   clock : rising-edge clock for all state
//   reset : synchronous active-high reset (pointers, count and data_out to 0)
//   bus   : fifo_if slave port (clear/write/read/data_in in,
//           full/empty/data_out out)
// Priority at each edge: reset > clear > read/write. A write while full and
// a read while empty are ignored; data_out is registered and updates only on
// a successful pop.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic  clock,
    input  logic  reset,
    fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wptr_reg, wptr_next;
    logic [AW-1:0]    rptr_reg, rptr_next;
    logic [AW:0]      count_reg, count_next;
    logic [WIDTH-1:0] data_out_reg;

    logic full_flag;
    logic empty_flag;
    logic do_write;
    logic do_read;

    assign full_flag  = (count_reg == COUNT_FULL);
    assign empty_flag = (count_reg == '0);

    // clear discards any push/pop presented in the same cycle.
    assign do_write = bus.write && !full_flag  && !bus.clear;
    assign do_read  = bus.read  && !empty_flag && !bus.clear;

    assign bus.full     = full_flag;
    assign bus.empty    = empty_flag;
    assign bus.data_out = data_out_reg;

    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        count_next = count_reg;
        if (bus.clear) begin
            wptr_next  = '0;
            rptr_next  = '0;
            count_next = '0;
        end else begin
            if (do_write) begin
                wptr_next = wptr_reg + PTR_ONE;
            end
            if (do_read) begin
                rptr_next = rptr_reg + PTR_ONE;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_write, do_read})
                2'b10:   count_next = count_reg + COUNT_ONE;
                2'b01:   count_next = count_reg - COUNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            count_reg <= count_next;
        end
    end

    // Storage has no reset so it maps onto block RAM; contents after reset
    // are don't-care because the pointers and count are cleared.
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wptr_reg] <= bus.data_in;
        end
    end

    // Registered read port doubling as the data_out register.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_reg <= '0;
        end else if (do_read) begin
            data_out_reg <= mem[rptr_reg];
        end
    end
endmodule

// File: tb/tb_fifo.sv
module tb_fifo;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fifo_if #(.WIDTH(WIDTH)) bus ();

    fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge with the given strobes; outputs sampled 1ns after it.
    task automatic cyc(input logic w, input logic r, input logic c, input logic [31:0] d);
        bus.write   = w;
        bus.read    = r;
        bus.clear   = c;
        bus.data_in = d;
        @(posedge clock);
        #1;
        bus.write = 1'b0;
        bus.read  = 1'b0;
        bus.clear = 1'b0;
        $display("t=%0t rst=%0b clr=%0b wr=%0b rd=%0b din=%0d -> dout=%0d full=%0b empty=%0b",
                 $time, reset, c, w, r, d, bus.data_out, bus.full, bus.empty);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;
    endtask

    logic [31:0] fill_vals [8] = '{100, 150, 200, 40, 70, 65, 15, 230};

    initial begin
        bus.write   = 1'b0;
        bus.read    = 1'b0;
        bus.clear   = 1'b0;
        bus.data_in = '0;

        // Reset state
        do_reset();
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_dout", bus.data_out, 32'd0);

        // Ordering
        cyc(1'b1, 1'b0, 1'b0, 32'd100);
        check("ord_empty_fall", 32'(bus.empty), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'd150);
        cyc(1'b1, 1'b0, 1'b0, 32'd200);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        check("ord_pop1", bus.data_out, 32'd100);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        check("ord_pop2", bus.data_out, 32'd150);
        check("ord_notempty", 32'(bus.empty), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        check("ord_pop3", bus.data_out, 32'd200);
        check("ord_empty", 32'(bus.empty), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        check("ord_underflow_hold", bus.data_out, 32'd200);

        // Fill / full
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0, fill_vals[i]);
            if (i == 6) check("fill_full_at7", 32'(bus.full), 32'd0);
        end
        check("fill_full", 32'(bus.full), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'd99);
        check("fill_full_after_drop", 32'(bus.full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'd0);
            check($sformatf("fill_pop%0d", i), bus.data_out, fill_vals[i]);
            if (i == 0) check("fill_full_fall", 32'(bus.full), 32'd0);
        end
        check("fill_empty", 32'(bus.empty), 32'd1);

        // Wrap-around
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 32'(11 + i));
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'd0);
            check($sformatf("wrap_a_pop%0d", i), bus.data_out, 32'(11 + i));
        end
        check("wrap_a_empty", 32'(bus.empty), 32'd1);
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b0, 32'(i));
        check("wrap_full", 32'(bus.full), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'd0);
            check($sformatf("wrap_pop%0d", i), bus.data_out, 32'(i));
        end
        check("wrap_empty", 32'(bus.empty), 32'd1);
        check("wrap_notfull", 32'(bus.full), 32'd0);

        // Clear
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 32'(21 + i));
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        check("clr_pre_pop", bus.data_out, 32'd21);
        cyc(1'b1, 1'b0, 1'b1, 32'd77);
        check("clr_empty", 32'(bus.empty), 32'd1);
        check("clr_dout_hold", bus.data_out, 32'd21);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        check("clr_write_dropped", bus.data_out, 32'd21);
        cyc(1'b1, 1'b0, 1'b0, 32'd31);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        check("clr_post_pop", bus.data_out, 32'd31);
        check("clr_post_empty", 32'(bus.empty), 32'd1);

        // Simultaneous, mid-queue
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 32'(41 + i));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'(45 + i));
            check($sformatf("rw_pop%0d", i), bus.data_out, 32'(41 + i));
        end
        check("rw_notfull", 32'(bus.full), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'd0);
            check($sformatf("rw_drain%0d", i), bus.data_out, 32'(44 + i));
            if (i == 2) check("rw_count4", 32'(bus.empty), 32'd0);
        end
        check("rw_empty", 32'(bus.empty), 32'd1);

        // Simultaneous when full
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 32'(51 + i));
        cyc(1'b1, 1'b1, 1'b0, 32'd99);
        check("rwfull_pop", bus.data_out, 32'd51);
        check("rwfull_notfull", 32'(bus.full), 32'd0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'd0);
            check($sformatf("rwfull_drain%0d", i), bus.data_out, 32'(52 + i));
        end
        check("rwfull_empty7", 32'(bus.empty), 32'd1);

        // Simultaneous when empty
        cyc(1'b1, 1'b1, 1'b0, 32'd88);
        check("rwempty_dout_hold", bus.data_out, 32'd58);
        check("rwempty_stored", 32'(bus.empty), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        check("rwempty_pop", bus.data_out, 32'd88);
        check("rwempty_empty", 32'(bus.empty), 32'd1);

        // Reset mid-operation
        cyc(1'b1, 1'b0, 1'b0, 32'd5);
        do_reset();
        check("midrst_empty", 32'(bus.empty), 32'd1);
        check("midrst_dout", bus.data_out, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
